// File: rtl/filt_edge_event.sv
// Hold-time qualified edge-event generator fed by the upstream glitch filter.
// Optional saturating event counter enabled by defining FILT_EDGE_EVT_CNT_EN.
module filt_edge_event #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                filter_i,
  input  logic                rise_en_i,
  input  logic                fall_en_i,
  input  logic [CntWidth-1:0] hold_cycles_i,
  input  logic                evt_clr_i,
  output logic                evt_o,
  output logic                evt_pending_o,
  output logic                evt_type_o,
  output logic                busy_o,
  output logic [7:0]          evt_count_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  state_e              state_q;
  logic                prev_q;
  logic                lvl_q;
  logic [CntWidth-1:0] hold_q;
  logic [CntWidth-1:0] cnt_q;
  logic                evt_q;
  logic                pend_q;
  logic                type_q;

  logic edge_acc;
  logic fire;

  // A bounce out of COUNT is itself an edge, so the same qualifier drives restarts.
  assign edge_acc = (filter_i != prev_q) && (filter_i ? rise_en_i : fall_en_i);
  assign fire     = enable_i && (state_q == COUNT) && (filter_i == lvl_q) &&
                    (cnt_q == hold_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      lvl_q   <= 1'b0;
      hold_q  <= '0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      pend_q  <= 1'b0;
      type_q  <= 1'b0;
    end else begin
      prev_q <= filter_i;
      evt_q  <= 1'b0;
      if (evt_clr_i) begin
        pend_q <= 1'b0;
      end
      if (!enable_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (edge_acc) begin
              state_q <= COUNT;
              lvl_q   <= filter_i;
              cnt_q   <= '0;
              hold_q  <= hold_cycles_i;
            end
          end
          COUNT: begin
            if (fire) begin
              evt_q   <= 1'b1;
              type_q  <= lvl_q;
              pend_q  <= 1'b1;   // later assignment wins over a same-cycle clear
              state_q <= IDLE;
            end else if (filter_i == lvl_q) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (edge_acc) begin
              lvl_q  <= filter_i;
              cnt_q  <= '0;
              hold_q <= hold_cycles_i;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign evt_o         = evt_q;
  assign evt_pending_o = pend_q;
  assign evt_type_o    = type_q;
  assign busy_o        = (state_q == COUNT);

`ifdef FILT_EDGE_EVT_CNT_EN
  logic [7:0] evt_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      evt_cnt_q <= 8'd0;
    end else if (evt_clr_i) begin
      evt_cnt_q <= fire ? 8'd1 : 8'd0;
    end else if (fire && (evt_cnt_q != 8'hFF)) begin
      evt_cnt_q <= evt_cnt_q + 8'd1;
    end
  end

  assign evt_count_o = evt_cnt_q;
`else
  assign evt_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_filt_edge_event.sv
// Directed bench for filt_edge_event; cycle k starts 1 time unit after a rising edge.
// Inputs set in cycle k are sampled on the edge that ends cycle k.
module tb_filt_edge_event;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        filter;
  logic        rise_en;
  logic        fall_en;
  logic [15:0] hold;
  logic        clr;
  logic        evt;
  logic        pend;
  logic        typ;
  logic        busy;
  logic [7:0]  count;

  int errors = 0;
  int checks = 0;
  int n_evt  = 0;

`ifdef FILT_EDGE_EVT_CNT_EN
  localparam bit CntOn = 1'b1;
`else
  localparam bit CntOn = 1'b0;
`endif

  filt_edge_event #(.CntWidth(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .filter_i      (filter),
    .rise_en_i     (rise_en),
    .fall_en_i     (fall_en),
    .hold_cycles_i (hold),
    .evt_clr_i     (clr),
    .evt_o         (evt),
    .evt_pending_o (pend),
    .evt_type_o    (typ),
    .busy_o        (busy),
    .evt_count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; filter = 1'b0; rise_en = 1'b0;
    fall_en = 1'b0; hold = 16'd0; clr = 1'b0;
    tick(); tick(); tick();
    check("rst_evt", evt, 0);
    check("rst_pend", pend, 0);
    check("rst_type", typ, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic rise, hold 3: event in cycle 5, busy in cycles 1..4
    rise_en = 1'b1; hold = 16'd3;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 0) filter = 1'b1;
      check($sformatf("rise_evt_c%0d", k), evt, (k == 5));
      check($sformatf("rise_busy_c%0d", k), busy, (k >= 1 && k <= 4));
      if (k == 5) begin
        check("rise_type", typ, 1);
        check("rise_pend", pend, 1);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    check("rise_clr_pend", pend, 0);
    filter = 1'b0; tick(); tick();
    check("unqual_fall_busy", busy, 0);

    // Bounce abort with falling edges not qualified
    hold = 16'd4;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) filter = 1'b1;
      if (k == 2) filter = 1'b0;
      check($sformatf("abort_evt_c%0d", k), evt, 0);
      if (k >= 1 && k <= 3) check($sformatf("abort_busy_c%0d", k), busy, (k <= 2));
    end
    check("abort_pend", pend, 0);

    // Bounce restart: falling edge re-latches hold 0, event in cycle 4
    fall_en = 1'b1; hold = 16'd4;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 0) filter = 1'b1;
      if (k == 2) begin filter = 1'b0; hold = 16'd0; end
      check($sformatf("restart_evt_c%0d", k), evt, (k == 4));
      check($sformatf("restart_busy_c%0d", k), busy, (k >= 1 && k <= 3));
      if (k == 4) begin
        check("restart_type", typ, 0);
        check("restart_pend", pend, 1);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;

    // Zero hold: edges in cycles 0 and 10; clear in cycle 11 coincides with the firing edge
    hold = 16'd0;
    for (int k = 0; k <= 14; k++) begin
      tick();
      filter = (k >= 0 && k < 10);
      clr    = (k == 5 || k == 11 || k == 13);
      check($sformatf("zh_evt_c%0d", k), evt, (k == 2 || k == 12));
      if (k == 2)  check("zh_type_rise", typ, 1);
      if (k == 6)  check("zh_pend_cleared", pend, 0);
      if (k == 12) check("zh_type_fall", typ, 0);
      if (k == 12) check("zh_pend_fire_clr", pend, 1);
      if (k == 13) check("zh_pend_held", pend, 1);
      if (k == 14) check("zh_pend_clr", pend, 0);
    end
    clr = 1'b0;

    // Disable mid-count, then re-enable with filter stable
    hold = 16'd5;
    for (int k = 0; k <= 14; k++) begin
      tick();
      if (k == 0) filter = 1'b1;
      if (k == 2) enable = 1'b0;
      if (k == 5) enable = 1'b1;
      check($sformatf("dis_evt_c%0d", k), evt, 0);
      if (k == 3) check("dis_busy", busy, 0);
      if (k >= 6) check($sformatf("reen_busy_c%0d", k), busy, 0);
    end
    check("dis_pend", pend, 0);
    rise_en = 1'b0; fall_en = 1'b0; filter = 1'b0;
    tick(); tick();

    // Reset mid-count; filter still high at release is a fresh rising edge
    rise_en = 1'b1; hold = 16'd5;
    for (int k = 0; k <= 12; k++) begin
      tick();
      if (k == 0) filter = 1'b1;
      rst_n = (k != 2);
      check($sformatf("rstmid_evt_c%0d", k), evt, (k == 10));
      check($sformatf("rstmid_busy_c%0d", k), busy, ((k >= 1 && k <= 2) || (k >= 4 && k <= 9)));
      if (k == 3) begin
        check("rstmid_pend", pend, 0);
        check("rstmid_count", count, 0);
      end
      if (k == 10) check("rstmid_type", typ, 1);
    end
    clr = 1'b1; tick(); clr = 1'b0;

    // Counter saturation over 257 events, zero hold, toggling every 3 cycles
    fall_en = 1'b1; hold = 16'd0; n_evt = 0;
    for (int i = 0; i < 257; i++) begin
      filter = ~filter;
      tick(); n_evt += int'(evt);
      tick(); n_evt += int'(evt);
      tick(); n_evt += int'(evt);
      if (i == 253) check("cnt_254", count, CntOn ? 254 : 0);
      if (i == 255) check("cnt_256_sat", count, CntOn ? 255 : 0);
    end
    check("evt_tally", n_evt, 257);
    check("cnt_257_sat", count, CntOn ? 255 : 0);

    // Clear concurrent with fire leaves count at 1
    for (int k = 0; k <= 3; k++) begin
      if (k == 0) filter = ~filter;
      clr = (k == 1);
      tick();
    end
    clr = 1'b0;
    check("cnt_fire_clr", count, CntOn ? 1 : 0);
    check("cnt_fire_clr_pend", pend, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
